// File: rtl/microwave_pkg.sv
// Shared microwave-controller types and constants.
//   bcd_t           : one BCD digit (0-9 in 4 bits)
//   bcd_time_t      : MM:SS as four BCD digits, min_tens in the MSBs
//   BCD_NINE        : largest legal BCD digit, reload value on a borrow
//   SEC_TENS_RELOAD : sec_tens reload on a borrow (59 -> 00 roll)
package microwave_pkg;
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE        = 4'd9;
  localparam bcd_t SEC_TENS_RELOAD = 4'd5;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } bcd_time_t;
endpackage

// File: rtl/cook_timer_if.sv
// Keypad / control / display bundle of the cook timer.
//   master : keypad + magnetron side (drives clearn, digit_valid, digit,
//            magnetron_on; reads the four BCD digits, timer_done, beep)
//   slave  : the cook_timer itself
// beep exists only when COOK_TIMER_BEEP_EN is defined.
interface cook_timer_if;
  import microwave_pkg::*;

  logic clearn;
  logic digit_valid;
  bcd_t digit;
  logic magnetron_on;
  bcd_t min_tens, min_ones, sec_tens, sec_ones;
  logic timer_done;
`ifdef COOK_TIMER_BEEP_EN
  logic beep;

  modport master (output clearn, digit_valid, digit, magnetron_on,
                  input  min_tens, min_ones, sec_tens, sec_ones, timer_done, beep);
  modport slave  (input  clearn, digit_valid, digit, magnetron_on,
                  output min_tens, min_ones, sec_tens, sec_ones, timer_done, beep);
`else
  modport master (output clearn, digit_valid, digit, magnetron_on,
                  input  min_tens, min_ones, sec_tens, sec_ones, timer_done);
  modport slave  (input  clearn, digit_valid, digit, magnetron_on,
                  output min_tens, min_ones, sec_tens, sec_ones, timer_done);
`endif
endinterface

// File: rtl/cook_timer_bcd_down_digit.sv
// One BCD digit of the countdown chain.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero the digit (beats dec and load)
//   load       : take load_val (keypad shift)
//   dec        : decrement; at 0 reload with reload_val and borrow
//   q          : current digit
//   borrow_out : dec & (q == 0), feeds the next-higher digit's dec
module bcd_down_digit
  import microwave_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  input  bcd_t reload_val,
  output bcd_t q,
  output logic borrow_out
);
  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)       q_d = '0;
    else if (dec)  q_d = (q_q == '0) ? reload_val : q_q - 4'd1;
    else if (load) q_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q          = q_q;
  assign borrow_out = dec & (q_q == '0);
endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: MM:SS BCD entry from the keypad, one-second
// countdown while the magnetron runs, timer_done = time is 00:00.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cook_timer_if.slave (keypad, magnetron_on, display digits,
//              timer_done, optional beep)
// Parameters: CLK_HZ (cycles per second, >= 2), BEEP_SECS (beep length).
// Macro COOK_TIMER_BEEP_EN adds the expiry beeper and its seconds counter.
module cook_timer
  import microwave_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BEEP_SECS = 3
) (
  input logic        clk,
  input logic        rst,
  cook_timer_if.slave bus
);
  localparam int               CNT_W    = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic             clr, load, timer_done, run_cd, run, wrap, tick, kill_cnt;
  logic [3:0]       dec, borrow;
  logic             unused_borrow;
  bcd_t [3:0]       dig_q, ld_val, rl_val;  // [0] = sec_ones .. [3] = min_tens
  bcd_time_t        now_t;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign clr  = ~bus.clearn;
  // Entry only while stopped; out-of-range keys are dropped.
  assign load = ~bus.magnetron_on & bus.digit_valid & (bus.digit <= BCD_NINE);

  assign now_t      = dig_q;
  assign timer_done = (now_t == '0);
  // Countdown runs only with time left, so there is never a tick at 00:00.
  assign run_cd     = bus.magnetron_on & ~timer_done;
  assign wrap       = (cnt_q == CNT_LAST);
  assign tick       = run_cd & wrap;

  // Borrow chain, sec_ones first; sec_tens rolls to 5, the rest to 9.
  assign dec    = {borrow[2:0], tick};
  assign ld_val = {dig_q[2:0], bus.digit};
  assign rl_val = {BCD_NINE, BCD_NINE, SEC_TENS_RELOAD, BCD_NINE};
  assign unused_borrow = borrow[3];

  for (genvar i = 0; i < 4; i++) begin : g_dig
    bcd_down_digit u_dig (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .load       (load),
      .load_val   (ld_val[i]),
      .dec        (dec[i]),
      .reload_val (rl_val[i]),
      .q          (dig_q[i]),
      .borrow_out (borrow[i])
    );
  end

`ifdef COOK_TIMER_BEEP_EN
  localparam int SECS_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

  logic              beep_q, beep_d, expire, beep_last;
  logic [SECS_W-1:0] secs_q, secs_d;

  // The last decrement lands on 00:00 exactly when the time is 00:01.
  assign expire    = tick & (dig_q == 16'h0001);
  assign beep_last = beep_q & wrap & (secs_q == SECS_W'(BEEP_SECS - 1));

  always_comb begin
    beep_d = beep_q;
    secs_d = secs_q;
    if (clr || load) begin
      beep_d = 1'b0;
      secs_d = '0;
    end else if (expire) begin
      beep_d = 1'b1;
      secs_d = '0;
    end else if (beep_last) begin
      beep_d = 1'b0;
      secs_d = '0;
    end else if (beep_q && wrap) begin
      secs_d = secs_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beep_q <= 1'b0;
      secs_q <= '0;
    end else begin
      beep_q <= beep_d;
      secs_q <= secs_d;
    end
  end

  // The prescaler free-runs to time the beep; a key that cancels the beep
  // also drops the partial second so the next cook starts on a full one.
  assign run      = run_cd | beep_q;
  assign kill_cnt = load & beep_q;
  assign bus.beep = beep_q;
`else
  assign run      = run_cd;
  assign kill_cnt = 1'b0;
`endif

  // Prescaler holds while stopped, so pause/resume keeps the partial second.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || kill_cnt) cnt_d = '0;
    else if (run)        cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.min_tens   = now_t.min_tens;
  assign bus.min_ones   = now_t.min_ones;
  assign bus.sec_tens   = now_t.sec_tens;
  assign bus.sec_ones   = now_t.sec_ones;
  assign bus.timer_done = timer_done;
endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer with CLK_HZ=4, BEEP_SECS=2.
// Expected {timer_done, MM:SS} words are queued as stimulus is driven,
// DUT samples are queued as they appear, and each scenario drains both.
module tb_cook_timer;
  import microwave_pkg::*;

  localparam int CLK_HZ    = 4;
  localparam int BEEP_SECS = 2;

  logic clk = 1'b0;
  logic rst;
  cook_timer_if bus ();

  cook_timer #(.CLK_HZ(CLK_HZ), .BEEP_SECS(BEEP_SECS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] sb[$];
  logic [16:0] got[$];
  logic [16:0] exp_v, got_v;
  logic [15:0] m;

  // Inputs change and outputs are read 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] t);
    sb.push_back({(t == 16'h0000), t});
  endtask

  task automatic sample();
    got.push_back({bus.timer_done, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones});
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    step(1);
    bus.digit_valid = 1'b0;
  endtask

  task automatic clear();
    bus.clearn = 1'b0;
    step(1);
    bus.clearn = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.clearn = 1'b1; bus.digit_valid = 1'b0; bus.digit = '0;
    bus.magnetron_on = 1'b0;
    step(3);
    rst = 1'b0;
    push(16'h0000); sample();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL reset: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

  task automatic test_entry();
    push(16'h0001); key(4'd1); sample();
    push(16'h0013); key(4'd3); sample();
    push(16'h0130); key(4'd0); sample();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL entry: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

  task automatic test_ignored();
    push(16'h0130); key(4'd12); sample();
    push(16'h0130); key(4'd10); sample();
    bus.magnetron_on = 1'b1;
    push(16'h0130); key(4'd7); sample();
    bus.magnetron_on = 1'b0;
    push(16'h0000); clear(); sample();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL ignored: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

  task automatic test_wide_secs();
    push(16'h0009); key(4'd9); sample();
    push(16'h0090); key(4'd0); sample();
    bus.magnetron_on = 1'b1;
    push(16'h0089); step(4); sample();
    bus.magnetron_on = 1'b0;
    clear();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL wide_secs: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

  task automatic test_borrow();
    push(16'h0001); key(4'd1); sample();
    push(16'h0010); key(4'd0); sample();
    push(16'h0100); key(4'd0); sample();
    bus.magnetron_on = 1'b1;
    push(16'h0100); step(3);   sample();
    push(16'h0059); step(1);   sample();
    push(16'h0050); step(36);  sample();
    push(16'h0049); step(4);   sample();
    push(16'h0000); step(196); sample();
    push(16'h0000); step(8);   sample();
    bus.magnetron_on = 1'b0;
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL borrow: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

  task automatic test_pause();
    clear();
    push(16'h0005); key(4'd5); sample();
    bus.magnetron_on = 1'b1;
    push(16'h0004); step(6); sample();
    bus.magnetron_on = 1'b0;
    push(16'h0004); step(10); sample();
    bus.magnetron_on = 1'b1;
    push(16'h0004); step(1); sample();
    push(16'h0003); step(1); sample();
    bus.magnetron_on = 1'b0;
    clear();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL pause: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

  task automatic test_clear_priority();
    push(16'h0002); key(4'd2); sample();
    bus.magnetron_on = 1'b1;
    push(16'h0002); step(3); sample();
    bus.clearn = 1'b0;
    push(16'h0000); step(1); sample();
    bus.clearn = 1'b1;
    bus.magnetron_on = 1'b0;
    // A fresh 00:02 must take a full second, proving the prescaler was zeroed.
    push(16'h0002); key(4'd2); sample();
    bus.magnetron_on = 1'b1;
    push(16'h0002); step(3); sample();
    push(16'h0001); step(1); sample();
    bus.magnetron_on = 1'b0;
    clear();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL clear_prio: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

  task automatic test_reset_mid();
    push(16'h0004); key(4'd4); sample();
    bus.magnetron_on = 1'b1;
    step(2);
    rst = 1'b1;
    push(16'h0000); step(1); sample();
    rst = 1'b0;
    bus.magnetron_on = 1'b0;
    push(16'h0001); key(4'd1); sample();
    bus.magnetron_on = 1'b1;
    push(16'h0001); step(3); sample();
    push(16'h0000); step(1); sample();
    push(16'h0000); step(4); sample();
    bus.magnetron_on = 1'b0;
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL reset_mid: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

  task automatic test_back_to_back();
    int seq[6] = '{1, 2, 15, 3, 4, 5};
    logic [3:0] d;
    clear();
    m = 16'h0000;
    bus.digit_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 4'(seq[i]);
      bus.digit = d;
      if (d <= 4'd9) m = {m[11:0], d};
      push(m);
      step(1);
      sample();
    end
    bus.digit_valid = 1'b0;
    push(16'h2345); sample();
    clear();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL back_to_back: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask

`ifdef COOK_TIMER_BEEP_EN
  task automatic test_beep();
    int hi;
    key(4'd1);
    bus.magnetron_on = 1'b1;
    push(16'h0000); step(4); sample();
    bus.magnetron_on = 1'b0;
    hi = bus.beep ? 1 : 0;
    for (int i = 0; i < 20 && bus.beep; i++) begin
      step(1);
      if (bus.beep) hi++;
    end
    n_vec++;
    if (hi != 2 * CLK_HZ) begin n_err++; $display("FAIL beep_len: got %0d want %0d", hi, 2 * CLK_HZ); end
    key(4'd1);
    bus.magnetron_on = 1'b1;
    step(4);
    bus.magnetron_on = 1'b0;
    step(3);
    n_vec++;
    if (bus.beep !== 1'b1) begin n_err++; $display("FAIL beep_mid: got %b want 1", bus.beep); end
    push(16'h0005); key(4'd5); sample();
    n_vec++;
    if (bus.beep !== 1'b0) begin n_err++; $display("FAIL beep_cancel: got %b want 0", bus.beep); end
    clear();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front(); n_vec++;
      got_v = (got.size() != 0) ? got.pop_front() : 'x;
      if (got_v !== exp_v) begin n_err++; $display("FAIL beep_digits: got %h want %h", got_v, exp_v); end
    end
    got.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_entry();
    test_ignored();
    test_wide_secs();
    test_borrow();
    test_pause();
    test_clear_priority();
    test_reset_mid();
    test_back_to_back();
`ifdef COOK_TIMER_BEEP_EN
    test_beep();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
